// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, internal baud counter, mid-bit sampling,
// configurable data width, optional parity and one or two stop bits.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic           ODD       = (PARITY_ODD != 0);

    logic                 rx_meta_q, rx_s_q;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 stop_bad_q, stop_bad_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 stop_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Includes the current stop sample so the last stop bit counts toward the error flag.
    assign stop_fail = stop_bad_q | ~rx_s_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d    = DATA;
                        idx_d      = '0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    // LSB first: right shift leaves the first bit at position 0.
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rx_s_q) != ODD;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    stop_bad_d = stop_fail;
                    if (idx_q == LAST_STOP) begin
                        idx_d        = '0;
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        parity_err_d = par_bad_q;
                        frame_err_d  = stop_fail;
                        state_d      = stop_fail ? BREAK : IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations driven with directed frames; a frame-level
// model predicts each valid pulse and its payload, a negedge process compares every cycle.
module tb_uart_rx_cfg;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic [7:0] do0, do1;
    logic [6:0] do2;
    logic       dv [3];
    logic       pe [3];
    logic       fe [3];
    logic       bz [3];
    logic [8:0] dout [3];

    uart_rx_cfg u0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(do0), .data_valid(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0])
    );
    uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(do1), .data_valid(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1])
    );
    uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .rx(rx2), .data_out(do2), .data_valid(dv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2])
    );

    assign dout[0] = {1'b0, do0};
    assign dout[1] = {1'b0, do1};
    assign dout[2] = {2'b00, do2};

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    logic chk_en = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    typedef struct {
        int         inst;
        int         at;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } ev_t;

    ev_t        q[$];
    logic [8:0] exp_dout [3] = '{9'd0, 9'd0, 9'd0};
    int         total = 0;
    int         bad = 0;
    int         s0;

    task automatic chk(input string name, input int inst, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Sends one frame on the chosen receiver and records the pulse the receiver must give.
    // Pulse cycle: start edge is cyc+1, then 2 sync cycles, half a bit, then M full bits.
    task automatic send(input int inst, input logic [8:0] data, input int dbits, input int pen,
                        input logic podd, input logic pbit, input int nstop, input logic stopv,
                        input int hold, input int rst_bit);
        logic       bits[$];
        logic [8:0] d;
        ev_t        ev;
        d = data & ((9'd1 << dbits) - 9'd1);
        bits.push_back(1'b0);
        for (int j = 0; j < dbits; j++) bits.push_back(d[j]);
        if (pen != 0) bits.push_back(pbit);
        for (int j = 0; j < nstop; j++) bits.push_back(stopv);
        if (rst_bit < 0) begin
            ev.inst = inst;
            ev.at   = cyc + 3 + H + (dbits + pen + nstop) * C;
            ev.data = d;
            ev.pe   = (pen != 0) && (((^d) ^ pbit) != podd);
            ev.fe   = !stopv;
            q.push_back(ev);
        end
        for (int b = 0; b < int'(bits.size()); b++) begin
            set_rx(inst, bits[b]);
            for (int c = 0; c < C; c++) begin
                if (b == rst_bit && c == 4) rst = 1'b1;
                else if (b == rst_bit && c == 5) rst = 1'b0;
                @(posedge clk); #1;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        set_rx(inst, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic hit, ep, ef;
                if (rst_seen) exp_dout[i] = '0;
                hit = !rst_seen && q.size() > 0 && q[0].inst == i && q[0].at == cyc;
                ep  = 1'b0;
                ef  = 1'b0;
                if (hit) begin
                    exp_dout[i] = q[0].data;
                    ep = q[0].pe;
                    ef = q[0].fe;
                end
                chk("data_valid", i, {8'b0, dv[i]}, {8'b0, hit});
                chk("data_out", i, dout[i], exp_dout[i]);
                chk("parity_err", i, {8'b0, pe[i]}, {8'b0, ep});
                chk("frame_err", i, {8'b0, fe[i]}, {8'b0, ef});
                if (rst_seen) chk("busy_rst", i, {8'b0, bz[i]}, 9'd0);
            end
            if (q.size() > 0 && q[0].at <= cyc) q.pop_front();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // 8N1 0xA5: pulse exactly in cycle start+155, busy drops with it
        s0 = cyc;
        fork
            send(0, 9'hA5, 8, 0, 1'b0, 1'b0, 1, 1'b1, 0, -1);
            begin
                wait_to(s0 + 100); chk("busy_mid", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 154); chk("dv_early", 0, {8'b0, dv[0]}, 9'd0);
                wait_to(s0 + 155); chk("dv_lit", 0, {8'b0, dv[0]}, 9'd1);
                chk("dout_lit", 0, dout[0], 9'h0A5);
                chk("busy_pulse", 0, {8'b0, bz[0]}, 9'd0);
            end
        join
        idle(20);

        // 4-clock glitch: START then back to IDLE, no pulse
        s0 = cyc;
        fork
            begin
                rx0 = 1'b0;
                idle(4);
                rx0 = 1'b1;
            end
            begin
                wait_to(s0 + 2);  chk("glitch_b0", 0, {8'b0, bz[0]}, 9'd0);
                wait_to(s0 + 3);  chk("glitch_b1", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 10); chk("glitch_b2", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 11); chk("glitch_b3", 0, {8'b0, bz[0]}, 9'd0);
            end
        join
        idle(40);

        // Even parity, 0x07: parity bit 0 is wrong, 1 is right
        s0 = cyc;
        fork
            send(1, 9'h07, 8, 1, 1'b0, 1'b0, 1, 1'b1, 0, -1);
            begin wait_to(s0 + 171); chk("perr_lit", 1, {8'b0, pe[1]}, 9'd1); end
        join
        idle(10);
        s0 = cyc;
        fork
            send(1, 9'h07, 8, 1, 1'b0, 1'b1, 1, 1'b1, 0, -1);
            begin wait_to(s0 + 171); chk("pok_lit", 1, {8'b0, pe[1]}, 9'd0);
                  chk("pok_dv", 1, {8'b0, dv[1]}, 9'd1); end
        join
        idle(10);

        // 0x3C with a low stop bit, line held low 40 more clocks
        s0 = cyc;
        fork
            send(0, 9'h3C, 8, 0, 1'b0, 1'b0, 1, 1'b0, 40, -1);
            begin
                wait_to(s0 + 155); chk("ferr_lit", 0, {8'b0, fe[0]}, 9'd1);
                chk("ferr_dout", 0, dout[0], 9'h03C);
                chk("ferr_busy", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 202); chk("brk_busy1", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 203); chk("brk_busy0", 0, {8'b0, bz[0]}, 9'd0);
            end
        join
        idle(60);

        // 7 data bits, 2 stop bits, back-to-back frames 10 bit periods apart
        s0 = cyc;
        fork
            begin
                send(2, 9'h55, 7, 0, 1'b0, 1'b0, 2, 1'b1, 0, -1);
                send(2, 9'h2A, 7, 0, 1'b0, 1'b0, 2, 1'b1, 0, -1);
            end
            begin
                wait_to(s0 + 155); chk("b2b_dv1", 2, {8'b0, dv[2]}, 9'd1);
                chk("b2b_d1", 2, dout[2], 9'h055);
                wait_to(s0 + 315); chk("b2b_dv2", 2, {8'b0, dv[2]}, 9'd1);
                chk("b2b_d2", 2, dout[2], 9'h02A);
            end
        join
        idle(40);

        // Reset during data bit 4 of an all-ones frame, then a clean 0x81
        s0 = cyc;
        fork
            send(0, 9'hFF, 8, 0, 1'b0, 1'b0, 1, 1'b1, 0, 5);
            begin
                wait_to(s0 + 84); chk("pre_rst_busy", 0, {8'b0, bz[0]}, 9'd1);
                wait_to(s0 + 85); chk("rst_busy", 0, {8'b0, bz[0]}, 9'd0);
                chk("rst_dout", 0, dout[0], 9'h000);
            end
        join
        idle(200);
        s0 = cyc;
        fork
            send(0, 9'h81, 8, 0, 1'b0, 1'b0, 1, 1'b1, 0, -1);
            begin wait_to(s0 + 155); chk("post_rst", 0, dout[0], 9'h081); end
        join
        idle(40);

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_events got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
